// File: rtl/cell_renderer_if.sv
// Pixel-stream, field-read and ant-state signals between the timing/logic side and cell_renderer.
// slave is the renderer's view; master is the environment's view.
interface cell_renderer_if #(
    parameter int CW = 3
);
    logic          iframe_start;
    logic          ide;
    logic          ihsync;
    logic          ivsync;
    logic [CW-1:0] oline;
    logic [CW-1:0] ocolumn;
    logic [2:0]    idata;
    logic [CW-1:0] icur_pos_x;
    logic [CW-1:0] icur_pos_y;
    logic [1:0]    idirection;
    logic [2:0]    orgb;
    logic          ode;
    logic          ohsync;
    logic          ovsync;

    modport slave (
        input  iframe_start, ide, ihsync, ivsync, idata, icur_pos_x, icur_pos_y, idirection,
        output oline, ocolumn, orgb, ode, ohsync, ovsync
    );

    modport master (
        output iframe_start, ide, ihsync, ivsync, idata, icur_pos_x, icur_pos_y, idirection,
        input  oline, ocolumn, orgb, ode, ohsync, ovsync
    );
endinterface

// File: rtl/cell_renderer.sv
// Maps active video to cell indices and renders grid/ant/cell colour; 2-cycle latency, no backpressure.
// Define CELL_RENDERER_GRID_EN to draw grid lines (rx==0 or ry==0) in green.
module cell_renderer #(
    parameter int C_NUM_OF_CELLS_X = 5,
    parameter int C_NUM_OF_CELLS_Y = 5,
    parameter int C_CELL_WIDTH     = 16,
    parameter int C_CELL_HEIGHT    = 16
) (
    input  logic           iclk,
    input  logic           irst_n,
    cell_renderer_if.slave vid
);
    localparam int CW = $clog2((C_NUM_OF_CELLS_X + C_NUM_OF_CELLS_Y) / 2);
    localparam int XW = $clog2(C_CELL_WIDTH);
    localparam int YW = $clog2(C_CELL_HEIGHT);

    localparam logic [XW-1:0] RX_LAST   = XW'(C_CELL_WIDTH - 1);
    localparam logic [YW-1:0] RY_LAST   = YW'(C_CELL_HEIGHT - 1);
    localparam logic [XW-1:0] RX_RIGHT  = XW'(C_CELL_WIDTH - 2);
    localparam logic [YW-1:0] RY_DOWN   = YW'(C_CELL_HEIGHT - 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(C_NUM_OF_CELLS_X - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(C_NUM_OF_CELLS_Y - 1);

    logic [XW-1:0] rx_q, rx_d;
    logic [YW-1:0] ry_q, ry_d;
    logic [CW-1:0] column_q, column_d;
    logic [CW-1:0] line_q, line_d;
    logic          x_out_q, x_out_d;
    logic          y_out_q, y_out_d;
    logic          frame_ok_q, frame_ok_d;

    logic [XW-1:0] rx1_q;
    logic [YW-1:0] ry1_q;
    logic          out1_q, hit1_q, de1_q, hs1_q, vs1_q;
    logic [1:0]    dir1_q;

    logic [2:0]    rgb_q, rgb_d;
    logic          de2_q, hs2_q, vs2_q;
    logic          marker;

    // de1_q doubles as the previous-cycle ide for falling-edge detection.
    always_comb begin
        rx_d       = rx_q;
        ry_d       = ry_q;
        column_d   = column_q;
        line_d     = line_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        frame_ok_d = frame_ok_q;
        if (vid.iframe_start) begin
            rx_d       = '0;
            ry_d       = '0;
            column_d   = '0;
            line_d     = '0;
            x_out_d    = 1'b0;
            y_out_d    = 1'b0;
            frame_ok_d = 1'b1;
        end else if (vid.ide) begin
            if (rx_q == RX_LAST) begin
                rx_d = '0;
                if (column_q == COL_LAST) x_out_d  = 1'b1;
                else                      column_d = column_q + 1'b1;
            end else begin
                rx_d = rx_q + 1'b1;
            end
        end else if (de1_q) begin
            rx_d     = '0;
            column_d = '0;
            x_out_d  = 1'b0;
            if (ry_q == RY_LAST) begin
                ry_d = '0;
                if (line_q == LINE_LAST) y_out_d = 1'b1;
                else                     line_d  = line_q + 1'b1;
            end else begin
                ry_d = ry_q + 1'b1;
            end
        end
    end

    always_comb begin
        case (dir1_q)
            2'd0:    marker = (ry1_q < YW'(2));
            2'd1:    marker = (rx1_q >= RX_RIGHT);
            2'd2:    marker = (ry1_q >= RY_DOWN);
            default: marker = (rx1_q < XW'(2));
        endcase
        rgb_d = vid.idata;
        if (!de1_q || !frame_ok_q)       rgb_d = 3'b000;
        else if (out1_q)                 rgb_d = 3'b000;
`ifdef CELL_RENDERER_GRID_EN
        else if (rx1_q == '0 || ry1_q == '0) rgb_d = 3'b010;
`endif
        else if (hit1_q && marker)       rgb_d = 3'b110;
        else if (hit1_q)                 rgb_d = 3'b100;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            rx_q       <= '0;
            ry_q       <= '0;
            column_q   <= '0;
            line_q     <= '0;
            x_out_q    <= 1'b0;
            y_out_q    <= 1'b0;
            frame_ok_q <= 1'b0;
            rx1_q      <= '0;
            ry1_q      <= '0;
            out1_q     <= 1'b0;
            hit1_q     <= 1'b0;
            dir1_q     <= 2'd0;
            de1_q      <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            rgb_q      <= 3'b000;
            de2_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
        end else begin
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            column_q   <= column_d;
            line_q     <= line_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            frame_ok_q <= frame_ok_d;
            rx1_q      <= rx_q;
            ry1_q      <= ry_q;
            out1_q     <= x_out_q | y_out_q;
            hit1_q     <= (column_q == vid.icur_pos_x) && (line_q == vid.icur_pos_y);
            dir1_q     <= vid.idirection;
            de1_q      <= vid.ide;
            hs1_q      <= vid.ihsync;
            vs1_q      <= vid.ivsync;
            rgb_q      <= rgb_d;
            de2_q      <= de1_q;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
        end
    end

    assign vid.oline   = line_q;
    assign vid.ocolumn = column_q;
    assign vid.orgb    = rgb_q;
    assign vid.ode     = de2_q;
    assign vid.ohsync  = hs2_q;
    assign vid.ovsync  = vs2_q;
endmodule
